// File: rtl/instr_input_stage.sv
// Board front end: synchronises switches and the send button, debounces the button and
// turns each debounced press into a one-cycle strobe plus a valid/ready instruction hand-off.
module instr_input_stage #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        send_button,
    input  logic [17:0] switches,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [17:0] instr_data,
    output logic        send_button_pulse,
    output logic        busy_led,
    output logic        overrun,
    output logic [7:0]  press_count
);

    typedef enum logic [1:0] {
        S_LOW,
        S_RISE,
        S_HIGH,
        S_FALL
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic        btn_meta_q;
    logic        btn_s_q;
    logic [17:0] sw_meta_q;
    logic [17:0] sw_s_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_evt;

    logic        valid_q, valid_d;
    logic [17:0] data_q, data_d;
    logic        pulse_q;
    logic        overrun_q, overrun_d;
    logic [7:0]  count_q, count_d;
    logic        xfer;
    logic        hold_free;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            sw_meta_q  <= '0;
            sw_s_q     <= '0;
        end else begin
            btn_meta_q <= send_button;
            btn_s_q    <= btn_meta_q;
            sw_meta_q  <= switches;
            sw_s_q     <= sw_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Only a completed rise produces an event; a completed fall is silent.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_evt = 1'b0;
        case (state_q)
            S_LOW: begin
                if (btn_s_q) begin
                    cnt_d   = '0;
                    state_d = S_RISE;
                end
            end
            S_RISE: begin
                if (!btn_s_q) begin
                    state_d = S_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_HIGH;
                    press_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (!btn_s_q) begin
                    cnt_d   = '0;
                    state_d = S_FALL;
                end
            end
            S_FALL: begin
                if (btn_s_q) begin
                    state_d = S_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign xfer      = valid_q & instr_ready;
    assign hold_free = ~valid_q | xfer;

    // A press on the same edge as a transfer refills the register instead of overrunning.
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        count_d   = count_q;
        if (xfer) begin
            valid_d = 1'b0;
        end
        if (press_evt) begin
            count_d = count_q + 8'd1;
            if (hold_free) begin
                valid_d = 1'b1;
                data_d  = sw_s_q;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            pulse_q   <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            pulse_q   <= press_evt;
            overrun_q <= overrun_d;
            count_q   <= count_d;
        end
    end

    assign instr_valid       = valid_q;
    assign instr_data        = data_q;
    assign send_button_pulse = pulse_q;
    assign busy_led          = valid_q;
    assign overrun           = overrun_q;
    assign press_count       = count_q;

endmodule

// File: tb/tb_instr_input_stage.sv
// Bench for instr_input_stage with a 4-cycle debounce: stimulus queues the expected
// state for every press strobe, and a negedge monitor matches strobes against that queue.
module tb_instr_input_stage;

    logic        clk;
    logic        reset;
    logic        send_button;
    logic [17:0] switches;
    logic        instr_ready;
    logic        instr_valid;
    logic [17:0] instr_data;
    logic        send_button_pulse;
    logic        busy_led;
    logic        overrun;
    logic [7:0]  press_count;

    int tests;
    int fails;
    int cyc;

    typedef struct {
        int          at_cyc;
        logic [17:0] data;
        logic        ovr;
        logic [7:0]  cnt;
    } exp_t;

    exp_t exp_q[$];

    instr_input_stage #(.DEBOUNCE_CYCLES(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .send_button       (send_button),
        .switches          (switches),
        .instr_ready       (instr_ready),
        .instr_valid       (instr_valid),
        .instr_data        (instr_data),
        .send_button_pulse (send_button_pulse),
        .busy_led          (busy_led),
        .overrun           (overrun),
        .press_count       (press_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every strobe must match the oldest queued expectation, at its predicted cycle.
    always @(negedge clk) begin
        if (send_button_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_cycle", cyc, e.at_cyc);
                chk("pulse_data", {14'd0, instr_data}, {14'd0, e.data});
                chk("pulse_valid", {31'd0, instr_valid}, 32'd1);
                chk("pulse_busy", {31'd0, busy_led}, 32'd1);
                chk("pulse_overrun", {31'd0, overrun}, {31'd0, e.ovr});
                chk("pulse_count", {24'd0, press_count}, {24'd0, e.cnt});
            end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].at_cyc) begin
            chk("pulse_missing", cyc, exp_q[0].at_cyc);
            void'(exp_q.pop_front());
        end
    end

    task automatic chk_zero_outputs();
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_data", {14'd0, instr_data}, 32'd0);
        chk("rst_pulse", {31'd0, send_button_pulse}, 32'd0);
        chk("rst_busy", {31'd0, busy_led}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_count", {24'd0, press_count}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) begin
            tick();
            chk_zero_outputs();
        end
        reset = 1'b0;
    endtask

    // Button rises after edge t0; the event edge is t0+7 (2 sync stages + S_RISE entry + 4 counts).
    task automatic press(input logic [17:0] sw, input logic [17:0] exp_data, input logic exp_ovr,
                         input logic [7:0] exp_cnt, input int hold, input bit bounce,
                         input bit ready_at_evt);
        switches = sw;
        repeat (3) tick();
        send_button = 1'b1;
        exp_q.push_back('{cyc + 7, exp_data, exp_ovr, exp_cnt});
        for (int i = 0; i < hold; i++) begin
            if (ready_at_evt && i == 6) instr_ready = 1'b1;
            tick();
            if (ready_at_evt && i == 6) instr_ready = 1'b0;
        end
        if (bounce) begin
            for (int b = 0; b < 4; b++) begin
                send_button = b[0];
                repeat (2) tick();
            end
        end
        send_button = 1'b0;
        repeat (12) tick();
    endtask

    task automatic consume();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset       = 1'b1;
        send_button = 1'b1;
        switches    = 18'h3FFFF;
        instr_ready = 1'b0;

        // Button held through reset: one full debounce after release, then one event.
        do_reset();
        exp_q.push_back('{cyc + 7, 18'h3FFFF, 1'b0, 8'd1});
        repeat (10) tick();
        send_button = 1'b0;
        repeat (12) tick();
        chk("held_valid", {31'd0, instr_valid}, 32'd1);
        chk("held_data", {14'd0, instr_data}, {14'd0, 18'h3FFFF});
        consume();
        chk("held_consumed", {31'd0, instr_valid}, 32'd0);
        chk("held_busy_off", {31'd0, busy_led}, 32'd0);

        // Clean press and handshake.
        do_reset();
        press(18'h2A5F3, 18'h2A5F3, 1'b0, 8'd1, 20, 1'b0, 1'b0);
        chk("clean_valid", {31'd0, instr_valid}, 32'd1);
        chk("clean_count", {24'd0, press_count}, 32'd1);
        consume();
        chk("xfer_valid", {31'd0, instr_valid}, 32'd0);
        chk("xfer_data_held", {14'd0, instr_data}, {14'd0, 18'h2A5F3});

        // 3-cycle glitch is rejected.
        send_button = 1'b1;
        repeat (3) tick();
        send_button = 1'b0;
        repeat (15) tick();
        chk("glitch_count", {24'd0, press_count}, 32'd1);
        chk("glitch_valid", {31'd0, instr_valid}, 32'd0);

        // Press with a bouncy release: one event only.
        press(18'h00011, 18'h00011, 1'b0, 8'd2, 8, 1'b1, 1'b0);
        chk("bounce_count", {24'd0, press_count}, 32'd2);
        chk("bounce_data", {14'd0, instr_data}, {14'd0, 18'h00011});

        // Overrun: second press while 0x00011 is pending.
        press(18'h00022, 18'h00011, 1'b1, 8'd3, 8, 1'b0, 1'b0);
        chk("ovr_flag", {31'd0, overrun}, 32'd1);
        chk("ovr_data", {14'd0, instr_data}, {14'd0, 18'h00011});
        chk("ovr_valid", {31'd0, instr_valid}, 32'd1);

        // Transfer and press event on the same edge.
        do_reset();
        press(18'h00011, 18'h00011, 1'b0, 8'd1, 8, 1'b0, 1'b0);
        press(18'h00022, 18'h00022, 1'b0, 8'd2, 10, 1'b0, 1'b1);
        chk("sim_valid", {31'd0, instr_valid}, 32'd1);
        chk("sim_data", {14'd0, instr_data}, {14'd0, 18'h00022});
        chk("sim_overrun", {31'd0, overrun}, 32'd0);

        // 256 consumed presses wrap the counter to zero.
        do_reset();
        instr_ready = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            logic [17:0] sw;
            sw = 18'(i * 4099 + 7);
            press(sw, sw, 1'b0, 8'(i), 8, 1'b0, 1'b0);
        end
        instr_ready = 1'b0;
        chk("wrap_count", {24'd0, press_count}, 32'd0);
        chk("wrap_overrun", {31'd0, overrun}, 32'd0);
        chk("wrap_valid", {31'd0, instr_valid}, 32'd0);

        repeat (10) tick();
        chk("pending_pulses", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
